norm_apply_engine: RTL and testbench
====================================

Name: norm_apply_engine

Overview:
- Consumer of the LayerNorm statistics: takes the per-vector mean (Q8.8) and variance (Q16.16) and streams the same int8 vector a second time.
- Computes y = round(((x - mean) * rsqrt(var + EPS)) * gamma + beta) and emits int8 results.
- Sits between the mean/variance stage and the activation writeback path in the LayerNorm datapath.
- Iterative sqrt and reciprocal setup, then a 3-stage valid/ready streaming pipeline.

Parameters:
- EPS, 32'd1, epsilon added to var_in, Q16.16 unsigned.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stats_valid  in  1  mean_in/var_in valid
- stats_ready  out  1  high in S_IDLE only
- mean_in  in  16  signed Q8.8 mean
- var_in  in  32  unsigned Q16.16 variance
- din_valid  in  1  input element valid
- din_ready  out  1  element accepted when valid&&ready
- din  in  8  signed int8 element
- gamma  in  16  signed Q8.8 scale, sampled with din
- beta  in  16  signed Q8.8 shift, sampled with din
- din_last  in  1  last element of vector
- dout_valid  out  1  output valid
- dout_ready  in  1  downstream ready
- dout  out  8  signed int8 result
- dout_last  out  1  din_last delayed with its element
- done  out  1  one-cycle pulse after last output handed off

Behaviour:
- Reset is asynchronous, active-low rst_n; clock is clk. Reset clears state to S_IDLE, all pipeline valids to 0, and the registered stats.
- Reset values: stats_ready=1, din_ready=0, dout_valid=0, dout=0, dout_last=0, done=0.
- Reset mid-operation aborts the vector with no output; the next stats handshake starts clean.
- States: S_IDLE -> S_SQRT -> S_RECIP -> S_STREAM -> S_DRAIN -> S_DONE -> S_IDLE.
- S_IDLE: on stats_valid, latch mean_in and v = var_in + EPS (33-bit, saturate to 32'hFFFFFFFF).
- Handshake at cycle T gives S_SQRT for T+1..T+16, S_RECIP for T+17..T+33, S_STREAM from T+34.
- stats_valid outside S_IDLE is ignored.
- S_SQRT: 16-iteration bit-by-bit restoring integer sqrt. S = floor(sqrt(v)), 16-bit, which is std in Q8.8.
- S_RECIP: 17-iteration restoring divide, inv = floor(65536 / S), inv std in Q8.8.
  - inv saturates to 65535 when the quotient exceeds 65535.
  - S==0 forces inv=65535.
- S_STREAM: din_ready = !stall, where stall = dout_valid && !dout_ready.
- Pipeline advances only when !stall; when stalled, all stages hold and dout is stable.
- Stage 1: xc = (sext(din)<<8) - mean, 17-bit signed. Register gamma, beta, last.
- Stage 2: p = (xc * {0,inv}) >>> 8, full precision, arithmetic shift (floor).
- Stage 3: q = ((p * gamma) >>> 8) + sext(beta). r = (q + 128) >>> 8, round half up. Saturate r to [-128,127] into dout.
- No intermediate saturation.
- Latency: 3 cycles from din accept to dout_valid when not stalled. Throughput: 1 element per cycle.
- After the din_last beat is accepted, din_ready drops and the state goes to S_DRAIN.
- S_DRAIN exits when the output with dout_last=1 is handed off (dout_valid && dout_ready).
- S_DONE lasts one cycle with done=1, then S_IDLE.
- A vector is defined solely by din_last; there is no length port.

Test Plan:
- mean=0x0000, var=0x00010000, EPS=0, gamma=0x0100, beta=0; din=5, -7, 127 -> dout=5, -7, 127. din_ready first high 34 cycles after the stats handshake.
- mean=0x0200, var=0x00040000 (S=512, inv=128), gamma=1.0, beta=0; din=10, -6 -> dout=4, -4. done pulses one cycle after the last handoff.
- var=0, EPS=0 (S=0, inv=65535), mean=0, gamma=1.0, beta=0; din=1, -1, 0 -> dout=127, -128, 0 (saturation).
- mean=0, var=1.0, EPS=0, gamma=1.0, beta=0x0080; din=3, -3 -> dout=4, -2 (round half up).
- Random dout_ready toggling over a 16-element vector -> outputs match the golden model in order. dout is stable while stalled, no drops or duplicates, dout_last on element 16 only.
- Assert rst_n low mid-S_STREAM -> next cycle dout_valid=0, stats_ready=1. A fresh vector afterwards produces correct results.

Source files
------------

// File: rtl/norm_apply_engine.sv
// norm_apply_engine: second pass of LayerNorm. Turns the variance into a
// reciprocal standard deviation with an iterative sqrt and divide, then
// streams y = round(((x - mean) * inv_std) * gamma + beta) as int8.
module norm_apply_engine #(
    parameter logic [31:0] EPS = 32'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stats_valid,
    output logic        stats_ready,
    input  logic [15:0] mean_in,
    input  logic [31:0] var_in,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [7:0]  din,
    input  logic [15:0] gamma,
    input  logic [15:0] beta,
    input  logic        din_last,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [7:0]  dout,
    output logic        dout_last,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQRT,
        S_RECIP,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t       state_q;
    logic         stats_ready_q;
    logic         done_q;
    logic [4:0]   cnt_q;
    logic [15:0]  mean_q;
    logic [15:0]  inv_q;

    // sqrt working registers
    logic [31:0]  rad_q;
    logic [17:0]  rem_q;
    logic [15:0]  root_q;

    // divide working registers
    logic [16:0]  dvd_q;
    logic [16:0]  drem_q;
    logic [15:0]  quot_q;

    // pipeline registers
    logic                s1_v_q, s1_last_q;
    logic signed [16:0]  s1_xc_q;
    logic signed [15:0]  s1_g_q, s1_b_q;
    logic                s2_v_q, s2_last_q;
    logic signed [25:0]  s2_p_q;
    logic signed [15:0]  s2_g_q, s2_b_q;
    logic                dout_valid_q, dout_last_q;
    logic [7:0]          dout_q;

    // combinational helpers
    logic [32:0]         v_sum;
    logic [31:0]         v_sat;
    logic [19:0]         sq_rem_sh, sq_trial;
    logic                sq_ge;
    logic [17:0]         rem_d;
    logic [15:0]         root_d;
    logic [17:0]         dv_rem_sh;
    logic                dv_ge;
    logic [16:0]         drem_d;
    logic [16:0]         quot_d;
    logic [15:0]         inv_d;
    logic                stall, accept, out_fire;
    logic signed [16:0]  xc_d;
    logic signed [33:0]  xc_ext, inv_ext, p_full;
    logic signed [25:0]  p_d;
    logic signed [41:0]  p_ext, g_ext, pg;
    logic signed [34:0]  q_d;
    logic signed [26:0]  r_d;
    logic [7:0]          sat_d;

    assign stall      = dout_valid_q && !dout_ready;
    assign din_ready  = (state_q == S_STREAM) && !stall;
    assign accept     = din_valid && din_ready;
    assign out_fire   = dout_valid_q && dout_ready;

    assign stats_ready = stats_ready_q;
    assign done        = done_q;
    assign dout_valid  = dout_valid_q;
    assign dout        = dout_q;
    assign dout_last   = dout_last_q;

    // Setup arithmetic: epsilon add, one sqrt step, one divide step
    always_comb begin
        v_sum     = {1'b0, var_in} + {1'b0, EPS};
        v_sat     = v_sum[32] ? '1 : v_sum[31:0];

        sq_rem_sh = {rem_q, rad_q[31:30]};
        sq_trial  = {2'b00, root_q, 2'b01};
        sq_ge     = (sq_rem_sh >= sq_trial);
        rem_d     = sq_ge ? 18'(sq_rem_sh - sq_trial) : 18'(sq_rem_sh);
        root_d    = {root_q[14:0], sq_ge};

        dv_rem_sh = {drem_q, dvd_q[16]};
        dv_ge     = (dv_rem_sh >= {2'b00, root_q});
        drem_d    = dv_ge ? 17'(dv_rem_sh - {2'b00, root_q}) : 17'(dv_rem_sh);
        quot_d    = {quot_q, dv_ge};
        inv_d     = ((root_q == 16'd0) || quot_d[16]) ? 16'hFFFF : quot_d[15:0];
    end

    // Datapath arithmetic for the three pipeline stages
    always_comb begin
        xc_d    = {din[7], din, 8'h00} - {mean_q[15], mean_q};
        xc_ext  = {{17{s1_xc_q[16]}}, s1_xc_q};
        inv_ext = {18'd0, inv_q};
        p_full  = xc_ext * inv_ext;
        p_d     = 26'(p_full >>> 8);
        p_ext   = {{16{s2_p_q[25]}}, s2_p_q};
        g_ext   = {{26{s2_g_q[15]}}, s2_g_q};
        pg      = p_ext * g_ext;
        q_d     = 35'(pg >>> 8) + {{19{s2_b_q[15]}}, s2_b_q};
        r_d     = 27'((q_d + 35'sd128) >>> 8);
        if (r_d > 27'sd127) begin
            sat_d = 8'h7F;
        end else if (r_d < -27'sd128) begin
            sat_d = 8'h80;
        end else begin
            sat_d = r_d[7:0];
        end
    end

    // Control FSM with iterative sqrt/reciprocal setup
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            stats_ready_q <= 1'b1;
            done_q        <= 1'b0;
            cnt_q         <= '0;
            mean_q        <= '0;
            inv_q         <= '0;
            rad_q         <= '0;
            rem_q         <= '0;
            root_q        <= '0;
            dvd_q         <= '0;
            drem_q        <= '0;
            quot_q        <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (stats_valid) begin
                        mean_q        <= mean_in;
                        rad_q         <= v_sat;
                        rem_q         <= '0;
                        root_q        <= '0;
                        cnt_q         <= '0;
                        stats_ready_q <= 1'b0;
                        state_q       <= S_SQRT;
                    end
                end
                S_SQRT: begin
                    rad_q  <= rad_q << 2;
                    rem_q  <= rem_d;
                    root_q <= root_d;
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == 5'd15) begin
                        cnt_q   <= '0;
                        dvd_q   <= 17'h10000;
                        drem_q  <= '0;
                        quot_q  <= '0;
                        state_q <= S_RECIP;
                    end
                end
                S_RECIP: begin
                    dvd_q  <= dvd_q << 1;
                    drem_q <= drem_d;
                    quot_q <= quot_d[15:0];
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == 5'd16) begin
                        // quot_d carries the full 17-bit quotient on the final step
                        inv_q   <= inv_d;
                        cnt_q   <= '0;
                        state_q <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (accept && din_last) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_fire && dout_last_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    stats_ready_q <= 1'b1;
                    state_q       <= S_IDLE;
                end
                default: begin
                    stats_ready_q <= 1'b1;
                    state_q       <= S_IDLE;
                end
            endcase
        end
    end

    // Three-stage streaming pipeline, frozen as a whole while the output stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q       <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_xc_q      <= '0;
            s1_g_q       <= '0;
            s1_b_q       <= '0;
            s2_v_q       <= 1'b0;
            s2_last_q    <= 1'b0;
            s2_p_q       <= '0;
            s2_g_q       <= '0;
            s2_b_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            dout_q       <= '0;
        end else if (!stall) begin
            s1_v_q <= accept;
            if (accept) begin
                s1_xc_q   <= xc_d;
                s1_g_q    <= gamma;
                s1_b_q    <= beta;
                s1_last_q <= din_last;
            end
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_p_q    <= p_d;
                s2_g_q    <= s1_g_q;
                s2_b_q    <= s1_b_q;
                s2_last_q <= s1_last_q;
            end
            dout_valid_q <= s2_v_q;
            dout_last_q  <= s2_v_q && s2_last_q;
            if (s2_v_q) begin
                dout_q <= sat_d;
            end
        end
    end

endmodule

// File: tb/tb_norm_apply_engine.sv
// Self-checking bench for norm_apply_engine: directed vectors with known
// results plus randomized vectors scored against a plain-arithmetic model.
module tb_norm_apply_engine;

    localparam logic [31:0] EPS  = 32'd0;
    localparam longint      VMAX = 64'h0000_0000_FFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic        stats_valid;
    logic        stats_ready;
    logic [15:0] mean_in;
    logic [31:0] var_in;
    logic        din_valid;
    logic        din_ready;
    logic [7:0]  din;
    logic [15:0] gamma;
    logic [15:0] beta;
    logic        din_last;
    logic        dout_valid;
    logic        dout_ready;
    logic [7:0]  dout;
    logic        dout_last;
    logic        done;

    norm_apply_engine #(.EPS(EPS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stats_valid (stats_valid),
        .stats_ready (stats_ready),
        .mean_in     (mean_in),
        .var_in      (var_in),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .din         (din),
        .gamma       (gamma),
        .beta        (beta),
        .din_last    (din_last),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout        (dout),
        .dout_last   (dout_last),
        .done        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    int     v_din [32];
    int     v_g   [32];
    int     v_b   [32];
    int     v_exp [32];
    int     vec_n;
    int     cur_mean;
    longint cur_var;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reciprocal std in Q8.8 from the variance, by plain search and division
    function automatic longint model_inv(input longint var_v);
        longint v, s, q;
        v = var_v + longint'(EPS);
        if (v > VMAX) v = VMAX;
        s = 0;
        while ((s + 1) * (s + 1) <= v) s++;
        if (s == 0) return 65535;
        q = 65536 / s;
        return (q > 65535) ? 65535 : q;
    endfunction

    function automatic int model_elem(input int d, input int g, input int b,
                                      input int mean_v, input longint inv);
        longint xc, p, q, r;
        xc = longint'(d) * 256 - longint'(mean_v);
        p  = (xc * inv) >>> 8;
        q  = ((p * longint'(g)) >>> 8) + longint'(b);
        r  = (q + 128) >>> 8;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    task automatic fill_model();
        longint inv;
        inv = model_inv(cur_var);
        for (int i = 0; i < vec_n; i++)
            v_exp[i] = model_elem(v_din[i], v_g[i], v_b[i], cur_mean, inv);
    endtask

    task automatic fill_random(input int n);
        vec_n    = n;
        cur_mean = int'($urandom_range(0, 24576)) - 12288;
        cur_var  = longint'($urandom_range(32'h4000, 32'h40_0000));
        for (int i = 0; i < n; i++) begin
            v_din[i] = int'($urandom_range(0, 255)) - 128;
            v_g[i]   = int'($urandom_range(0, 1023)) - 512;
            v_b[i]   = int'($urandom_range(0, 2047)) - 1024;
        end
        fill_model();
    endtask

    task automatic send_stats(input bit check_lat);
        int lat;
        stats_valid = 1'b1;
        mean_in     = 16'(cur_mean);
        var_in      = 32'(cur_var);
        @(negedge clk);
        chk("stats_ready_idle", longint'(stats_ready), 1);
        @(posedge clk); #1;
        // stats offered while busy must be ignored
        mean_in = 16'h7FFF;
        var_in  = 32'h0000_1234;
        chk("stats_ready_busy", longint'(stats_ready), 0);
        lat = 1;
        while (!din_ready && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        stats_valid = 1'b0;
        if (check_lat) chk("din_ready_latency", longint'(lat), 34);
    endtask

    task automatic run_stream(input bit rand_ready, input int abort_at);
        int         idx_in = 0;
        int         n_out  = 0;
        int         cyc    = 0;
        bit         held_v = 1'b0;
        logic [7:0] held_d = '0;
        logic       held_l = 1'b0;
        while (n_out < vec_n && cyc < 3000) begin
            if (abort_at != 0 && cyc == abort_at) begin
                rst_n = 1'b0;
                din_valid = 1'b0;
                #1;
                chk("rst_dout_valid", longint'(dout_valid), 0);
                chk("rst_stats_ready", longint'(stats_ready), 1);
                chk("rst_din_ready", longint'(din_ready), 0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            if (idx_in < vec_n) begin
                din_valid = 1'b1;
                din       = 8'(v_din[idx_in]);
                gamma     = 16'(v_g[idx_in]);
                beta      = 16'(v_b[idx_in]);
                din_last  = (idx_in == vec_n - 1);
            end else begin
                din_valid = 1'b0;
                din       = 8'($urandom);
                din_last  = 1'b0;
            end
            dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (held_v) begin
                chk("stall_valid", longint'(dout_valid), 1);
                chk("stall_data", longint'($signed(dout)), longint'($signed(held_d)));
                chk("stall_last", longint'(dout_last), longint'(held_l));
            end
            held_v = 1'b0;
            if (dout_valid) begin
                if (dout_ready) begin
                    chk($sformatf("dout[%0d]", n_out), longint'($signed(dout)), longint'(v_exp[n_out]));
                    chk($sformatf("dout_last[%0d]", n_out), longint'(dout_last),
                        longint'(n_out == vec_n - 1));
                    n_out++;
                end else begin
                    held_v = 1'b1;
                    held_d = dout;
                    held_l = dout_last;
                end
            end
            if (idx_in == vec_n) chk("din_ready_drain", longint'(din_ready), 0);
            chk("done_quiet", longint'(done), 0);
            if (din_valid && din_ready) idx_in++;
            @(posedge clk); #1;
            cyc++;
        end
        din_valid = 1'b0;
        if (n_out < vec_n) begin
            chk("stream_timeout", longint'(n_out), longint'(vec_n));
        end else begin
            chk("done_pulse", longint'(done), 1);
            chk("stats_ready_in_done", longint'(stats_ready), 0);
            @(posedge clk); #1;
            chk("done_clear", longint'(done), 0);
            chk("stats_ready_back", longint'(stats_ready), 1);
        end
    endtask

    task automatic set_elem(input int i, input int d, input int g, input int b, input int e);
        v_din[i] = d;
        v_g[i]   = g;
        v_b[i]   = b;
        v_exp[i] = e;
    endtask

    initial begin
        rst_n       = 1'b0;
        stats_valid = 1'b0;
        mean_in     = '0;
        var_in      = '0;
        din_valid   = 1'b0;
        din         = '0;
        gamma       = '0;
        beta        = '0;
        din_last    = 1'b0;
        dout_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stats_ready", longint'(stats_ready), 1);
        chk("rst_din_ready", longint'(din_ready), 0);
        chk("rst_dout_valid", longint'(dout_valid), 0);
        chk("rst_dout", longint'(dout), 0);
        chk("rst_dout_last", longint'(dout_last), 0);
        chk("rst_done", longint'(done), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // unit std, identity affine
        cur_mean = 0; cur_var = 64'h1_0000; vec_n = 3;
        set_elem(0, 5, 256, 0, 5);
        set_elem(1, -7, 256, 0, -7);
        set_elem(2, 127, 256, 0, 127);
        send_stats(1'b1);
        run_stream(1'b0, 0);

        // mean 2.0, std 2.0
        cur_mean = 512; cur_var = 64'h4_0000; vec_n = 2;
        set_elem(0, 10, 256, 0, 4);
        set_elem(1, -6, 256, 0, -4);
        send_stats(1'b1);
        run_stream(1'b0, 0);

        // zero variance: reciprocal saturates, outputs clamp
        cur_mean = 0; cur_var = 0; vec_n = 3;
        set_elem(0, 1, 256, 0, 127);
        set_elem(1, -1, 256, 0, -128);
        set_elem(2, 0, 256, 0, 0);
        send_stats(1'b1);
        run_stream(1'b0, 0);

        // beta 0.5 exercises round-half-up
        cur_mean = 0; cur_var = 64'h1_0000; vec_n = 2;
        set_elem(0, 3, 256, 128, 4);
        set_elem(1, -3, 256, 128, -2);
        send_stats(1'b1);
        run_stream(1'b0, 0);

        // S == 1: quotient 65536 saturates to 65535
        fill_random(4);
        cur_var = 1;
        fill_model();
        send_stats(1'b1);
        run_stream(1'b0, 0);

        // largest variance: S = 65535, inv = 1
        fill_random(4);
        cur_var = VMAX;
        fill_model();
        send_stats(1'b0);
        run_stream(1'b1, 0);

        // randomized vectors with downstream backpressure
        for (int k = 0; k < 3; k++) begin
            fill_random(16);
            send_stats(1'b0);
            run_stream(1'b1, 0);
        end

        // reset mid-stream, then a clean vector
        fill_random(16);
        send_stats(1'b0);
        run_stream(1'b0, 5);
        fill_random(16);
        send_stats(1'b1);
        run_stream(1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
